// File: rtl/branch_resolve_unit_pkg.sv
// Shared IDs, predictor counter encodings and decode helpers for the branch resolve unit.
package branch_pkg;

  localparam int unsigned ID_BEQ  = 15;
  localparam int unsigned ID_BNE  = 16;
  localparam int unsigned ID_BGT  = 17;
  localparam int unsigned ID_BGTE = 18;
  localparam int unsigned ID_BLE  = 19;
  localparam int unsigned ID_BLEQ = 20;
  localparam int unsigned ID_J    = 21;
  localparam int unsigned ID_JR   = 22;
  localparam int unsigned ID_JAL  = 23;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'd0;
  localparam ctr_t WNT = 2'd1;
  localparam ctr_t WT  = 2'd2;
  localparam ctr_t ST  = 2'd3;

  function automatic logic is_cond_branch(input int unsigned id);
    return (id >= ID_BEQ) && (id <= ID_BLEQ);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Instruction-in / result-out stream between register-read, the branch unit and fetch.
interface branch_resolve_unit_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] pc_in;
  logic [ID_W-1:0]   id_in;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] offset;
  logic              pred_in;
  logic              out_valid;
  logic              out_ready;
  logic              taken;
  logic [DATA_W-1:0] next_pc;
  logic [DATA_W-1:0] link_val;
  logic              link_we;
  logic              mispredict;
  logic              warn_signal;

  modport master (
    output in_valid, pc_in, id_in, rs_val, rt_val, offset, pred_in, out_ready,
    input  in_ready, out_valid, taken, next_pc, link_val, link_we, mispredict, warn_signal
  );

  modport slave (
    input  in_valid, pc_in, id_in, rs_val, rt_val, offset, pred_in, out_ready,
    output in_ready, out_valid, taken, next_pc, link_val, link_we, mispredict, warn_signal
  );
endinterface

// File: rtl/branch_resolve_unit_bht_table.sv
// PC-indexed table of 2-bit saturating direction counters with a combinational read port.
module bht_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_taken,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  ctr_t ctr [ENTRIES];

  function automatic ctr_t sat_inc(input ctr_t c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic ctr_t sat_dec(input ctr_t c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Read sees the pre-update value; a same-cycle write lands on the next edge.
  assign rd_taken = ctr[rd_idx][1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= WNT;
    end else if (upd_en) begin
      ctr[upd_idx] <= upd_taken ? sat_inc(ctr[upd_idx]) : sat_dec(ctr[upd_idx]);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolver: decodes, compares, computes next PC/link and trains the BHT.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 6,
  parameter int BHT_ENTRIES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] lk_pc,
  output logic              lk_taken,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic                     fire;
  int unsigned              id_int;
  logic signed [DATA_W-1:0] rs_s;
  logic signed [DATA_W-1:0] rt_s;
  logic        [DATA_W-1:0] pc_plus1;
  logic        [DATA_W-1:0] branch_tgt;
  logic        [DATA_W-1:0] jump_tgt;
  logic                     cond_taken;
  logic                     is_jump;
  logic                     known;
  logic                     taken_c;
  logic        [DATA_W-1:0] next_pc_c;
  logic                     link_we_c;
  logic        [DATA_W-1:0] link_val_c;
  logic                     lk_pc_unused;

  logic                     vld_p1;
  logic                     taken_p1;
  logic        [DATA_W-1:0] next_pc_p1;
  logic        [DATA_W-1:0] link_val_p1;
  logic                     link_we_p1;
  logic                     mispredict_p1;
  logic                     warn_p1;

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign fire         = bus.in_valid && bus.in_ready;

  assign id_int     = 32'(bus.id_in);
  assign rs_s       = $signed(bus.rs_val);
  assign rt_s       = $signed(bus.rt_val);
  assign pc_plus1   = bus.pc_in + {{(DATA_W-1){1'b0}}, 1'b1};
  assign branch_tgt = pc_plus1 + bus.offset;

  always_comb begin
    cond_taken = 1'b0;
    is_jump    = 1'b0;
    jump_tgt   = '0;
    known      = 1'b1;
    case (id_int)
      ID_BEQ:  cond_taken = (rs_s == rt_s);
      ID_BNE:  cond_taken = (rs_s != rt_s);
      ID_BGT:  cond_taken = (rs_s >  rt_s);
      ID_BGTE: cond_taken = (rs_s >= rt_s);
      ID_BLE:  cond_taken = (rs_s <  rt_s);
      ID_BLEQ: cond_taken = (rs_s <= rt_s);
      ID_J, ID_JAL: begin
        is_jump  = 1'b1;
        jump_tgt = bus.offset;
      end
      ID_JR: begin
        is_jump  = 1'b1;
        jump_tgt = bus.rs_val;
      end
      default: known = 1'b0;
    endcase
  end

  assign taken_c    = is_jump || cond_taken;
  assign next_pc_c  = is_jump ? jump_tgt : (cond_taken ? branch_tgt : pc_plus1);
  assign link_we_c  = (id_int == ID_JAL);
  assign link_val_c = link_we_c ? pc_plus1 : '0;

  // ---- stage p0 -> p1: result register, held while the consumer stalls ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      taken_p1      <= 1'b0;
      next_pc_p1    <= '0;
      link_val_p1   <= '0;
      link_we_p1    <= 1'b0;
      mispredict_p1 <= 1'b0;
      warn_p1       <= 1'b0;
    end else begin
      if (fire) begin
        vld_p1        <= 1'b1;
        taken_p1      <= taken_c;
        next_pc_p1    <= next_pc_c;
        link_val_p1   <= link_val_c;
        link_we_p1    <= link_we_c;
        mispredict_p1 <= taken_c ^ bus.pred_in;
        warn_p1       <= !known;
      end else if (bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = vld_p1;
  assign bus.taken       = taken_p1;
  assign bus.next_pc     = next_pc_p1;
  assign bus.link_val    = link_val_p1;
  assign bus.link_we     = link_we_p1;
  assign bus.mispredict  = mispredict_p1;
  assign bus.warn_signal = warn_p1;

  // Only the low PC bits index the predictor; aliasing is accepted.
  assign lk_pc_unused = ^lk_pc[DATA_W-1:IDX_W];

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (lk_pc[IDX_W-1:0]),
    .rd_taken  (lk_taken),
    .upd_en    (fire && is_cond_branch(id_int)),
    .upd_idx   (bus.pc_in[IDX_W-1:0]),
    .upd_taken (cond_taken)
  );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors in, queued expectations checked by a monitor.
module tb_branch_resolve_unit;

  typedef struct {
    logic        taken;
    logic [31:0] next_pc;
    logic [31:0] link_val;
    logic        link_we;
    logic        mis;
    logic        warn;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] lk_pc;
  logic        lk_taken;
  int          checks;
  int          failures;
  exp_t        sb[$];
  exp_t        mon_e;

  branch_resolve_unit_if #(.DATA_W(32), .ID_W(6)) bus ();

  branch_resolve_unit #(
    .DATA_W      (32),
    .ID_W        (6),
    .BHT_ENTRIES (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .lk_pc    (lk_pc),
    .lk_taken (lk_taken),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input int id, input logic [31:0] pc, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] off, input logic pred,
                      input logic e_taken, input logic [31:0] e_next, input logic e_lwe,
                      input logic [31:0] e_lval, input logic e_mis, input logic e_warn);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.id_in    = 6'(id);
    bus.pc_in    = pc;
    bus.rs_val   = rs;
    bus.rt_val   = rt;
    bus.offset   = off;
    bus.pred_in  = pred;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 20);
    if (!bus.in_ready) begin
      chk("send_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      e.taken = e_taken; e.next_pc = e_next; e.link_val = e_lval;
      e.link_we = e_lwe; e.mis = e_mis; e.warn = e_warn;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(bus.out_valid), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("taken",      32'(bus.taken),       32'(mon_e.taken));
        chk("next_pc",    bus.next_pc,          mon_e.next_pc);
        chk("link_val",   bus.link_val,         mon_e.link_val);
        chk("link_we",    32'(bus.link_we),     32'(mon_e.link_we));
        chk("mispredict", 32'(bus.mispredict),  32'(mon_e.mis));
        chk("warn",       32'(bus.warn_signal), 32'(mon_e.warn));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    lk_pc = '0;
    bus.in_valid = 1'b0; bus.id_in = '0; bus.pc_in = '0; bus.rs_val = '0;
    bus.rt_val = '0; bus.offset = '0; bus.pred_in = 1'b0; bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_next_pc",   bus.next_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      lk_pc = 32'(i);
      #1;
      chk("rst_lk_taken", 32'(lk_taken), 32'd0);
    end
    chk("rst_taken",    32'(bus.taken),       32'd0);
    chk("rst_link_val", bus.link_val,         32'd0);
    chk("rst_link_we",  32'(bus.link_we),     32'd0);
    chk("rst_mis",      32'(bus.mispredict),  32'd0);
    chk("rst_warn",     32'(bus.warn_signal), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready),    32'd1);

    // beq twice at pc=10 trains counter 01 -> 10 -> 11
    lk_pc = 32'd10;
    @(posedge clk); #1;
    send(15, 32'd10, 32'd12, 32'd12, 32'd5, 1'b0, 1'b1, 32'd16, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("lk_after_1", 32'(lk_taken), 32'd1);
    send(15, 32'd10, 32'd12, 32'd12, 32'd5, 1'b0, 1'b1, 32'd16, 1'b0, 32'd0, 1'b1, 1'b0);
    chk("lk_after_2", 32'(lk_taken), 32'd1);

    // signed compares, negative offset, wrap-around
    send(17, 32'd50, 32'hFFFF_FFFF, 32'd1, 32'd7, 1'b1, 1'b0, 32'd51, 1'b0, 32'd0, 1'b1, 1'b0);
    send(20, 32'd20, 32'd10, 32'd10, 32'hFFFF_FFFD, 1'b1, 1'b1, 32'd18, 1'b0, 32'd0, 1'b0, 1'b0);
    send(16, 32'd1, 32'd3, 32'd4, 32'd2, 1'b1, 1'b1, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0);
    send(18, 32'h33, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd10, 1'b0, 1'b1, 32'h3E, 1'b0, 32'd0, 1'b1, 1'b0);
    send(19, 32'h17, 32'hFFFF_FFFE, 32'd1, 32'h10, 1'b1, 1'b1, 32'h28, 1'b0, 32'd0, 1'b0, 1'b0);
    send(19, 32'h1C, 32'd1, 32'hFFFF_FFFE, 32'h10, 1'b0, 1'b0, 32'h1D, 1'b0, 32'd0, 1'b0, 1'b0);
    send(15, 32'hFFFF_FFFE, 32'd7, 32'd7, 32'd5, 1'b1, 1'b1, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0);

    // jumps: targets and link, no BHT training
    send(23, 32'd40, 32'd0, 32'd0, 32'd100, 1'b1, 1'b1, 32'd100, 1'b1, 32'd41, 1'b0, 1'b0);
    send(22, 32'd41, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1, 32'd5, 1'b0, 32'd0, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    lk_pc = 32'd40;         #1; chk("lk_jal_idx8",  32'(lk_taken), 32'd0);
    lk_pc = 32'd41;         #1; chk("lk_jr_idx9",   32'(lk_taken), 32'd0);
    lk_pc = 32'd50;         #1; chk("lk_bgt_idx2",  32'(lk_taken), 32'd0);
    lk_pc = 32'd20;         #1; chk("lk_bleq_idx4", 32'(lk_taken), 32'd1);
    lk_pc = 32'hFFFF_FFFE;  #1; chk("lk_wrap_idx14", 32'(lk_taken), 32'd1);
    lk_pc = 32'h1C;         #1; chk("lk_ble_idx12", 32'(lk_taken), 32'd0);

    // backpressure: A held, B waits three cycles without training the BHT
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(15, 32'd5, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 32'd0, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.id_in = 6'd16; bus.pc_in = 32'd6; bus.rs_val = 32'd1;
    bus.rt_val = 32'd2; bus.offset = 32'd3; bus.pred_in = 1'b1;
    lk_pc = 32'd6;
    repeat (3) begin
      @(negedge clk);
      chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
      chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall_next_pc",   bus.next_pc,        32'd6);
      chk("stall_lk",        32'(lk_taken),      32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    mon_e.taken = 1'b1; mon_e.next_pc = 32'd10; mon_e.link_val = 32'd0;
    mon_e.link_we = 1'b0; mon_e.mis = 1'b0; mon_e.warn = 1'b0;
    sb.push_back(mon_e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("lk_after_release", 32'(lk_taken), 32'd1);

    // unknown ID on a counter at 10: must not be trained
    send(30, 32'd55, 32'd1, 32'd1, 32'd9, 1'b1, 1'b0, 32'd56, 1'b0, 32'd0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    lk_pc = 32'd55; #1; chk("lk_warn_idx7", 32'(lk_taken), 32'd1);

    // reset while a result is held
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.id_in = 6'd15; bus.pc_in = 32'd10; bus.rs_val = 32'd4;
    bus.rt_val = 32'd4; bus.offset = 32'd5; bus.pred_in = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("held_out_valid", 32'(bus.out_valid), 32'd1);
    chk("held_next_pc",   bus.next_pc,        32'd16);
    #2;
    reset = 1'b1;
    #1;
    chk("async_out_valid", 32'(bus.out_valid), 32'd0);
    chk("async_next_pc",   bus.next_pc,        32'd0);
    chk("async_taken",     32'(bus.taken),     32'd0);
    lk_pc = 32'd10; #1; chk("async_lk_idx10", 32'(lk_taken), 32'd0);
    lk_pc = 32'd20; #1; chk("async_lk_idx4",  32'(lk_taken), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Registered, parametrised successor to the combinational branch unit.
- Resolves branch/jump instructions and computes the absolute next PC and the jal link value.
- Owns a PC-indexed branch history table (BHT) of 2-bit saturating counters and flags mispredictions against the prediction carried with each instruction.
- Sits between decode/register-read and fetch: fetch queries the BHT combinationally, and the resolved stream redirects fetch.

Parameters:
- DATA_W, 32, width of PC, operands, offset and targets
- ID_W, 6, width of the decoded instruction ID
- BHT_ENTRIES, 16, number of predictor counters (power of two, >= 2)
- IDX_W, $clog2(BHT_ENTRIES), BHT index width (derived, not overridden)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- lk_pc  in  DATA_W  fetch PC for prediction lookup
- lk_taken  out  1  prediction for lk_pc; equals counter[lk_pc[IDX_W-1:0]][1] (combinational)
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept
- pc_in  in  DATA_W  PC of the instruction (word address)
- id_in  in  ID_W  decoded instruction ID
- rs_val  in  DATA_W  first operand; jump target for jr
- rt_val  in  DATA_W  second operand
- offset  in  DATA_W  sign-extended branch offset, or absolute target for j/jal
- pred_in  in  1  prediction fetch used for this instruction
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- taken  out  1  resolved direction
- next_pc  out  DATA_W  resolved next PC
- link_val  out  DATA_W  pc_in+1 for jal, else 0
- link_we  out  1  write link_val to $31 (jal only)
- mispredict  out  1  taken != pred_in
- warn_signal  out  1  id_in is not a branch/jump ID

Behaviour:
- Reset (async, immediate): out_valid, taken, next_pc, link_val, link_we, mispredict and warn_signal all 0. Every BHT counter is set to 2'b01 (weakly not-taken).
- Handshake:
  - in_ready = !out_valid || out_ready.
  - fire = in_valid && in_ready.
  - Latency is one cycle: a result fired in cycle N presents on the outputs in cycle N+1.
  - Outputs hold stable while out_valid && !out_ready.
  - On out_valid && out_ready with no new fire, out_valid drops to 0.
  - Back-to-back fire each cycle gives full throughput.
- ID decode (signed compare of rs_val and rt_val):
  - 15 beq: taken if rs == rt
  - 16 bne: taken if rs != rt
  - 17 bgt: taken if rs > rt
  - 18 bgte: taken if rs >= rt
  - 19 ble: taken if rs < rt
  - 20 bleq: taken if rs <= rt
  - 21 j: always taken
  - 22 jr: always taken
  - 23 jal: always taken
- Next PC:
  - Conditional branch taken: next_pc = pc_in + 1 + offset (modulo 2^DATA_W, wraps silently).
  - Conditional branch not taken: next_pc = pc_in + 1.
  - j and jal: next_pc = offset.
  - jr: next_pc = rs_val.
  - jal: link_we = 1, link_val = pc_in + 1.
- Any other ID: warn_signal = 1, taken = 0, next_pc = pc_in + 1, link_we = 0, mispredict = pred_in.
- BHT update on fire, conditional branches only (IDs 15-20):
  - Index is pc_in[IDX_W-1:0].
  - Taken increments the counter, saturating at 3; not-taken decrements it, saturating at 0.
  - Jumps and unknown IDs do not touch the BHT.
- Lookup and update to the same index in the same cycle: lk_taken returns the pre-update value; the new value is visible next cycle.
- Aliasing PCs share a counter; this is intended.
- Reset asserted mid-transfer discards the held result; no BHT state survives.

Decomposition:
- Package branch_pkg:
  - ID localparams ID_BEQ=15 through ID_JAL=23
  - counter encodings SNT=0, WNT=1, WT=2, ST=3
  - function is_cond_branch(id)
- Sub-module bht_table (params ENTRIES, IDX_W):
  - async-reset counter array
  - combinational read port
  - update port with saturating increment/decrement
- Top: decode/compare, target adder, output register, handshake.

Test Plan:
- Reset, then lk_pc=0..15 -> lk_taken=0 for all; every output 0.
- beq id=15, pc=10, rs=12, rt=12, offset=5, pred=0 -> next cycle taken=1, next_pc=16, mispredict=1; after 2 such fires at pc=10, lk_pc=10 gives lk_taken=1.
- bgt id=17, rs=-1 (0xFFFFFFFF), rt=1 -> taken=0, next_pc=pc+1. bleq id=20 with rs=rt=10, offset=-3 (0xFFFFFFFD), pc=20 -> next_pc=18.
- jal id=23, pc=40, offset=100 -> next_pc=100, link_we=1, link_val=41, BHT unchanged. jr id=22, rs=5 -> next_pc=5.
- out_ready held 0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable, no BHT update; release -> one fire per cycle.
- id=30 -> warn_signal=1, next_pc=pc+1. Assert reset while out_valid=1 -> out_valid=0 immediately and counters back to 01.
